parity_scrub: RTL and testbench

- Background scrubber for the raw-hits RAM parity datapath.
- When parity checking is enabled, it sweeps every raw-hits RAM read address so that latent parity errors are detected without waiting for an L1A readout.
- Shares the RAM read-address port with the sequencer readout; the sequencer always has priority.
- Tags its own reads through the RAM and parity latency, then counts errors and captures the first bad address for VME.

---
 rtl/parity_pkg.sv | 19 +
 rtl/parity_scrub_tag_pipe.sv | 35 +++
 rtl/parity_scrub.sv | 159 +++++++++++++++
 tb/tb_parity_scrub.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared constants for the raw-hits RAM parity scrubber.
// Holds FSM encodings, default widths and the saturating increment.
package parity_pkg;

   localparam int RAM_ADRB_DEF = 11;
   localparam int SAT_W        = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   function automatic logic [SAT_W-1:0] sat_inc(
      input logic [SAT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/parity_scrub_tag_pipe.sv
// Delay line that carries {valid, adr} of scrub reads
// alongside the RAM and parity latency.
module scrub_tag_pipe #(
   parameter int ADRB = 11,
   parameter int LAT  = 2
) (
   input  logic            clock,
   input  logic            global_reset_n,
   input  logic            issue_vld,
   input  logic [ADRB-1:0] issue_adr,
   output logic            tag_vld,
   output logic [ADRB-1:0] tag_adr
);

   logic [LAT-1:0]           vld_q;
   logic [LAT-1:0][ADRB-1:0] adr_q;

   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         vld_q <= '0;
         adr_q <= '0;
      end else begin
         vld_q[0] <= issue_vld;
         adr_q[0] <= issue_adr;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            adr_q[i] <= adr_q[i-1];
         end
      end
   end

   assign tag_vld = vld_q[LAT-1];
   assign tag_adr = adr_q[LAT-1];

endmodule

// File: rtl/parity_scrub.sv
// Background parity scrubber for the raw-hits RAM; shares the read
// port with the sequencer, which always wins arbitration.
module parity_scrub
   import parity_pkg::*;
#(
   parameter int RAM_ADRB = RAM_ADRB_DEF,
   parameter int RD_LAT   = 2,
   parameter int GAP_CNTB = 16
) (
   input  logic                clock,
   input  logic                global_reset_n,
   input  logic                scrub_en,
   input  logic                scrub_auto,
   input  logic [GAP_CNTB-1:0] scrub_gap,
   input  logic                scrub_start,
   input  logic                scrub_clr,
   input  logic                perr_en,
   input  logic                perr,
   input  logic                seq_rd_req,
   input  logic [RAM_ADRB-1:0] seq_rd_adr,
   output logic [RAM_ADRB-1:0] ram_rd_adr,
   output logic                seq_rd_gnt,
   output logic                scrub_busy,
   output logic                scrub_done,
   output logic [SAT_W-1:0]    scrub_pass_cnt,
   output logic [SAT_W-1:0]    scrub_err_cnt,
   output logic                scrub_err_vld,
   output logic [RAM_ADRB-1:0] scrub_err_adr
);

   localparam int DRW = $clog2(RD_LAT + 1);

   logic [1:0]          state;
   logic [RAM_ADRB-1:0] adr;
   logic [GAP_CNTB-1:0] gap_cnt;
   logic [DRW-1:0]      drn_cnt;
   logic                aborted;
   logic [SAT_W-1:0]    pass_cnt;
   logic [SAT_W-1:0]    err_cnt;
   logic                err_vld;
   logic [RAM_ADRB-1:0] err_adr;
   logic                run_ok;
   logic                rd_issue;
   logic                drn_last;
   logic                tag_vld;
   logic [RAM_ADRB-1:0] tag_adr;
   logic                err_hit;

   assign run_ok   = scrub_en && perr_en;
   assign rd_issue = (state == ST_SWEEP) && run_ok && !seq_rd_req;
   assign drn_last = (state == ST_DRAIN)
                  && (drn_cnt == DRW'(RD_LAT - 1));
   assign err_hit  = tag_vld && perr;

   assign seq_rd_gnt = seq_rd_req;
   assign ram_rd_adr = seq_rd_req ? seq_rd_adr : adr;

   assign scrub_busy     = (state == ST_SWEEP) || (state == ST_DRAIN);
   assign scrub_done     = drn_last && !aborted;
   assign scrub_pass_cnt = pass_cnt;
   assign scrub_err_cnt  = err_cnt;
   assign scrub_err_vld  = err_vld;
   assign scrub_err_adr  = err_adr;

   scrub_tag_pipe #(
      .ADRB (RAM_ADRB),
      .LAT  (RD_LAT)
   ) u_tag (
      .clock          (clock),
      .global_reset_n (global_reset_n),
      .issue_vld      (rd_issue),
      .issue_adr      (adr),
      .tag_vld        (tag_vld),
      .tag_adr        (tag_adr)
   );

   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state   <= ST_IDLE;
         adr     <= '0;
         gap_cnt <= '0;
         drn_cnt <= '0;
         aborted <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if ((scrub_start || scrub_auto) && run_ok) begin
                  state <= ST_SWEEP;
                  adr   <= '0;
               end
            end
            ST_SWEEP: begin
               if (!run_ok) begin
                  state   <= ST_DRAIN;
                  drn_cnt <= '0;
                  aborted <= 1'b1;
               end else if (rd_issue) begin
                  adr <= adr + 1'b1;
                  if (&adr) begin
                     state   <= ST_DRAIN;
                     drn_cnt <= '0;
                     aborted <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               if (drn_last) begin
                  if (!aborted && scrub_auto) begin
                     state   <= ST_GAP;
                     gap_cnt <= scrub_gap;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  drn_cnt <= drn_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               // a gap of N idles N cycles; 0 and 1 both give one cycle
               if (!scrub_en || !scrub_auto) begin
                  state <= ST_IDLE;
               end else if (gap_cnt < GAP_CNTB'(2)) begin
                  state <= perr_en ? ST_SWEEP : ST_IDLE;
                  adr   <= '0;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         pass_cnt <= '0;
         err_cnt  <= '0;
         err_vld  <= 1'b0;
         err_adr  <= '0;
      end else if (scrub_clr) begin
         pass_cnt <= '0;
         err_cnt  <= '0;
         err_vld  <= 1'b0;
         err_adr  <= '0;
      end else begin
         if (err_hit) begin
            err_cnt <= sat_inc(err_cnt);
            if (!err_vld) begin
               err_vld <= 1'b1;
               err_adr <= tag_adr;
            end
         end
         if (scrub_done) begin
            pass_cnt <= sat_inc(pass_cnt);
         end
      end
   end

endmodule

// File: tb/tb_parity_scrub.sv
// Scoreboard bench for parity_scrub with a 16-entry RAM model
// whose parity flag follows the read address by two cycles.
module tb_parity_scrub;

   logic        clock = 1'b0;
   logic        global_reset_n;
   logic        scrub_en, scrub_auto, scrub_start, scrub_clr;
   logic [15:0] scrub_gap;
   logic        perr_en, perr, seq_rd_req;
   logic [3:0]  seq_rd_adr, ram_rd_adr, scrub_err_adr;
   logic        seq_rd_gnt, scrub_busy, scrub_done, scrub_err_vld;
   logic [15:0] scrub_pass_cnt, scrub_err_cnt;

   int          nvec = 0;
   int          nerr = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  e;
   logic [15:0] bad = '0;
   logic [3:0]  hist0 = '0;
   logic [3:0]  hist1 = '0;
   logic        v_en = 1'b1, v_pe = 1'b1, v_auto = 1'b0;
   logic [15:0] v_gap = '0;

   parity_scrub #(.RAM_ADRB(4), .RD_LAT(2), .GAP_CNTB(16)) dut (
      .clock          (clock),
      .global_reset_n (global_reset_n),
      .scrub_en       (scrub_en),
      .scrub_auto     (scrub_auto),
      .scrub_gap      (scrub_gap),
      .scrub_start    (scrub_start),
      .scrub_clr      (scrub_clr),
      .perr_en        (perr_en),
      .perr           (perr),
      .seq_rd_req     (seq_rd_req),
      .seq_rd_adr     (seq_rd_adr),
      .ram_rd_adr     (ram_rd_adr),
      .seq_rd_gnt     (seq_rd_gnt),
      .scrub_busy     (scrub_busy),
      .scrub_done     (scrub_done),
      .scrub_pass_cnt (scrub_pass_cnt),
      .scrub_err_cnt  (scrub_err_cnt),
      .scrub_err_vld  (scrub_err_vld),
      .scrub_err_adr  (scrub_err_adr)
   );

   always #5 clock = ~clock;

   // one clock cycle: drive after the edge, sample at the falling edge
   task automatic step(input logic req, input logic [3:0] sadr,
                       input logic pinj, input logic start,
                       input logic clr);
      @(posedge clock);
      #1;
      seq_rd_req  = req;
      seq_rd_adr  = sadr;
      scrub_start = start;
      scrub_clr   = clr;
      scrub_en    = v_en;
      perr_en     = v_pe;
      scrub_auto  = v_auto;
      scrub_gap   = v_gap;
      perr        = pinj || bad[hist1];
      @(negedge clock);
      hist1 = hist0;
      hist0 = ram_rd_adr;
   endtask

   task automatic test_reset();
      nvec++;
      if ({scrub_busy, scrub_done, scrub_err_vld, seq_rd_gnt} !== 4'b0) begin
         nerr++;
         $display("FAIL reset_flags: got %b want 0000",
                  {scrub_busy, scrub_done, scrub_err_vld, seq_rd_gnt});
      end
      nvec++;
      if ({scrub_pass_cnt, scrub_err_cnt, scrub_err_adr, ram_rd_adr} !== 40'h0) begin
         nerr++;
         $display("FAIL reset_vals: got %h want 0",
                  {scrub_pass_cnt, scrub_err_cnt, scrub_err_adr, ram_rd_adr});
      end
   endtask

   task automatic test_single_pass();
      for (int a = 0; a < 16; a++) exp_q.push_back(4'(a));
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, 0);
         e = exp_q.pop_front();
         nvec++;
         if (ram_rd_adr !== e || scrub_busy !== 1'b1) begin
            nerr++;
            $display("FAIL pass_adr: got %0d busy %b want %0d busy 1",
                     ram_rd_adr, scrub_busy, e);
         end
      end
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_done !== 1'b0) begin
         nerr++;
         $display("FAIL pass_done_early: got %b want 0", scrub_done);
      end
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_done !== 1'b1) begin
         nerr++;
         $display("FAIL pass_done: got %b want 1", scrub_done);
      end
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_done !== 1'b0 || scrub_busy !== 1'b0) begin
         nerr++;
         $display("FAIL pass_end: done %b busy %b want 0 0",
                  scrub_done, scrub_busy);
      end
   endtask

   task automatic test_clean();
      test_single_pass();
      nvec++;
      if (scrub_pass_cnt !== 16'd1 || scrub_err_cnt !== 16'd0) begin
         nerr++;
         $display("FAIL clean_cnt: pass %0d err %0d want 1 0",
                  scrub_pass_cnt, scrub_err_cnt);
      end
   endtask

   task automatic test_errors();
      bad = 16'h0220;
      test_single_pass();
      bad = '0;
      nvec++;
      if (scrub_err_cnt !== 16'd2 || scrub_err_adr !== 4'd5
          || scrub_err_vld !== 1'b1 || scrub_pass_cnt !== 16'd2) begin
         nerr++;
         $display("FAIL err_capture: cnt %0d adr %0d vld %b pass %0d want 2 5 1 2",
                  scrub_err_cnt, scrub_err_adr, scrub_err_vld, scrub_pass_cnt);
      end
   endtask

   task automatic test_seq_priority();
      for (int a = 0; a < 7; a++) exp_q.push_back(4'(a));
      for (int a = 12; a < 15; a++) exp_q.push_back(4'(a));
      for (int a = 7; a < 16; a++) exp_q.push_back(4'(a));
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 19; i++) begin
         step(i >= 7 && i <= 9, 4'(12 + i - 7), i >= 9 && i <= 11,
              i == 3, 0);
         e = exp_q.pop_front();
         nvec++;
         if (ram_rd_adr !== e || seq_rd_gnt !== (i >= 7 && i <= 9)) begin
            nerr++;
            $display("FAIL seq_arb: slot %0d got %0d gnt %b want %0d",
                     i, ram_rd_adr, seq_rd_gnt, e);
         end
      end
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_done !== 1'b1) begin
         nerr++;
         $display("FAIL seq_done: got %b want 1", scrub_done);
      end
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_err_cnt !== 16'd2 || scrub_pass_cnt !== 16'd3) begin
         nerr++;
         $display("FAIL seq_cnt: err %0d pass %0d want 2 3",
                  scrub_err_cnt, scrub_pass_cnt);
      end
   endtask

   task automatic test_abort();
      bad = 16'h0200;
      for (int a = 0; a < 10; a++) exp_q.push_back(4'(a));
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0, 0);
         e = exp_q.pop_front();
         nvec++;
         if (ram_rd_adr !== e) begin
            nerr++;
            $display("FAIL abort_adr: got %0d want %0d", ram_rd_adr, e);
         end
      end
      v_pe = 1'b0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_done !== 1'b0 || scrub_busy !== 1'b1) begin
         nerr++;
         $display("FAIL abort_drain1: done %b busy %b want 0 1",
                  scrub_done, scrub_busy);
      end
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_done !== 1'b0 || scrub_busy !== 1'b1) begin
         nerr++;
         $display("FAIL abort_drain2: done %b busy %b want 0 1",
                  scrub_done, scrub_busy);
      end
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_busy !== 1'b0 || scrub_err_cnt !== 16'd3
          || scrub_err_adr !== 4'd5 || scrub_pass_cnt !== 16'd3
          || ram_rd_adr !== 4'd10) begin
         nerr++;
         $display("FAIL abort_end: busy %b err %0d adr %0d pass %0d rd %0d want 0 3 5 3 10",
                  scrub_busy, scrub_err_cnt, scrub_err_adr,
                  scrub_pass_cnt, ram_rd_adr);
      end
      bad = '0;
      v_pe = 1'b1;
   endtask

   task automatic test_auto_gap();
      v_auto = 1'b1;
      v_gap = 16'd3;
      for (int p = 0; p < 2; p++)
         for (int a = 0; a < 16; a++) exp_q.push_back(4'(a));
      step(0, 0, 0, 0, 0);
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 0);
            e = exp_q.pop_front();
            nvec++;
            if (ram_rd_adr !== e || scrub_busy !== 1'b1) begin
               nerr++;
               $display("FAIL auto_adr: pass %0d got %0d busy %b want %0d busy 1",
                        p, ram_rd_adr, scrub_busy, e);
            end
         end
         step(0, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0);
         nvec++;
         if (scrub_done !== 1'b1) begin
            nerr++;
            $display("FAIL auto_done: pass %0d got %b want 1", p, scrub_done);
         end
         if (p == 0) begin
            for (int g = 0; g < 3; g++) begin
               step(0, 0, 0, 0, 0);
               nvec++;
               if (scrub_busy !== 1'b0 || scrub_done !== 1'b0) begin
                  nerr++;
                  $display("FAIL auto_gap: cycle %0d busy %b done %b want 0 0",
                           g, scrub_busy, scrub_done);
               end
            end
         end
      end
      v_auto = 1'b0;
      for (int g = 0; g < 3; g++) begin
         step(0, 0, 0, 0, 0);
         nvec++;
         if (scrub_busy !== 1'b0) begin
            nerr++;
            $display("FAIL auto_stop: cycle %0d busy %b want 0", g, scrub_busy);
         end
      end
      nvec++;
      if (scrub_pass_cnt !== 16'd5) begin
         nerr++;
         $display("FAIL auto_pass_cnt: got %0d want 5", scrub_pass_cnt);
      end
   endtask

   task automatic test_sat_clr_reset();
      force dut.err_cnt = 16'hFFFF;
      #1;
      release dut.err_cnt;
      bad = 16'h0008;
      test_single_pass();
      bad = '0;
      nvec++;
      if (scrub_err_cnt !== 16'hFFFF || scrub_err_adr !== 4'd5
          || scrub_pass_cnt !== 16'd6) begin
         nerr++;
         $display("FAIL sat_cnt: err %h adr %0d pass %0d want ffff 5 6",
                  scrub_err_cnt, scrub_err_adr, scrub_pass_cnt);
      end
      bad = 16'h0010;
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, i == 6);
         if (i == 7) begin
            nvec++;
            if (scrub_err_cnt !== 16'd0 || scrub_err_vld !== 1'b0
                || scrub_err_adr !== 4'd0 || scrub_pass_cnt !== 16'd0) begin
               nerr++;
               $display("FAIL clr_wins: err %0d vld %b adr %0d pass %0d want 0 0 0 0",
                        scrub_err_cnt, scrub_err_vld, scrub_err_adr,
                        scrub_pass_cnt);
            end
         end
      end
      bad = '0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_pass_cnt !== 16'd1 || scrub_err_cnt !== 16'd0) begin
         nerr++;
         $display("FAIL clr_fsm: pass %0d err %0d want 1 0",
                  scrub_pass_cnt, scrub_err_cnt);
      end
      bad = 16'h0004;
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_err_cnt !== 16'd1 || scrub_err_adr !== 4'd2
          || scrub_busy !== 1'b1 || ram_rd_adr !== 4'd7) begin
         nerr++;
         $display("FAIL pre_reset: err %0d adr %0d busy %b rd %0d want 1 2 1 7",
                  scrub_err_cnt, scrub_err_adr, scrub_busy, ram_rd_adr);
      end
      global_reset_n = 1'b0;
      #1;
      test_reset();
      bad = '0;
      exp_q.delete();
      @(posedge clock);
      #1;
      global_reset_n = 1'b1;
      step(0, 0, 0, 0, 0);
      nvec++;
      if (scrub_busy !== 1'b0 || scrub_err_vld !== 1'b0) begin
         nerr++;
         $display("FAIL post_reset: busy %b vld %b want 0 0",
                  scrub_busy, scrub_err_vld);
      end
   endtask

   initial begin
      global_reset_n = 1'b0;
      scrub_en = 1'b0;
      scrub_auto = 1'b0;
      scrub_gap = '0;
      scrub_start = 1'b0;
      scrub_clr = 1'b0;
      perr_en = 1'b0;
      perr = 1'b0;
      seq_rd_req = 1'b0;
      seq_rd_adr = '0;
      repeat (3) @(posedge clock);
      #1;
      test_reset();
      global_reset_n = 1'b1;
      step(0, 0, 0, 0, 0);
      test_clean();
      test_errors();
      test_seq_priority();
      test_abort();
      test_auto_gap();
      test_sat_clr_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
